fwd_layer_mac: RTL and testbench

Sequencer and multiply-accumulate engine for one fully-connected forward-pass layer. It sits directly downstream of the training-phase state machine. Its `pass_i` input is driven by that machine's `f0_pass_o` level, and its `done_o` pulse drives the machine's `f0_end_i`. On each pass it computes every output neuron y[j] = act(Σ_i w[j][i]·x[i]) from external synchronous-read input and weight memories, then writes the results to an output memory.

---
 rtl/fwd_layer_mac.sv | 181 ++++++++++++++++++
 tb/tb_fwd_layer_mac.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_layer_mac.sv
// Sequences one fully-connected layer: reads x/w, accumulates, then writes act(acc) per neuron.
// Latency: 1 + N_OUT*(N_IN+2) cycles from pass sampling to done_o; en_i=0 freezes everything.
module fwd_layer_mac #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int ACCW  = 20,
  parameter int SHIFT = 0,
  localparam int XAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WAW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int YAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           pass_i,
  output logic           rd_en_o,
  output logic [XAW-1:0] x_addr_o,
  input  logic [DW-1:0]  x_data_i,
  output logic [WAW-1:0] w_addr_o,
  input  logic [DW-1:0]  w_data_i,
  output logic           y_we_o,
  output logic [YAW-1:0] y_addr_o,
  output logic [DW-1:0]  y_data_o,
  output logic           done_o,
  output logic           busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [XAW-1:0] I_LAST = XAW'(N_IN - 1);
  localparam logic [YAW-1:0] J_LAST = YAW'(N_OUT - 1);
  localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic [DW-1:0] Y_MAX_DW = {1'b0, {(DW - 1) {1'b1}}};

  state_t                 state_q, state_d;
  logic [XAW-1:0]         i_q, i_d;
  logic [YAW-1:0]         j_q, j_d;
  logic [WAW-1:0]         w_q, w_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   vld_q, vld_d;

  logic                   rd_en;
  logic                   y_we;
  logic                   done;

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_sh;
  logic [DW-1:0]          y_act;

  assign prod     = $signed(x_data_i) * $signed(w_data_i);
  assign prod_ext = ACCW'(prod);
  assign acc_sh   = acc_q >>> SHIFT;

  // ReLU below zero, saturate above the largest positive DW-bit value.
  always_comb begin
    y_act = acc_sh[DW-1:0];
    if (acc_sh < 0) begin
      y_act = '0;
    end else if (acc_sh > Y_MAX) begin
      y_act = Y_MAX_DW;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    w_d     = w_q;
    acc_d   = acc_q;
    vld_d   = 1'b0;
    rd_en   = 1'b0;
    y_we    = 1'b0;
    done    = 1'b0;

    if (vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    unique case (state_q)
      S_IDLE: begin
        acc_d = '0;
        i_d   = '0;
        j_d   = '0;
        w_d   = '0;
        if (pass_i) begin
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (!pass_i) begin
          state_d = S_IDLE;
          acc_d   = '0;
        end else begin
          rd_en = 1'b1;
          vld_d = 1'b1;
          w_d   = w_q + 1'b1;
          if (i_q == I_LAST) begin
            state_d = S_DRAIN;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!pass_i) begin
          state_d = S_IDLE;
          acc_d   = '0;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!pass_i) begin
          state_d = S_IDLE;
          acc_d   = '0;
        end else begin
          y_we  = 1'b1;
          acc_d = '0;
          i_d   = '0;
          if (j_q == J_LAST) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!pass_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The valid flag is frozen with everything else, so a stalled read still lands on resume.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
    end
  end

  assign rd_en_o  = rd_en & en_i;
  assign y_we_o   = y_we & en_i;
  assign done_o   = done & en_i;
  assign x_addr_o = i_q;
  assign w_addr_o = w_q;
  assign y_addr_o = j_q;
  assign y_data_o = y_act;
  assign busy_o   = (state_q == S_MAC) || (state_q == S_DRAIN) ||
                    (state_q == S_WRITE) || (state_q == S_DONE);

endmodule

// File: tb/tb_fwd_layer_mac.sv
// Bench for fwd_layer_mac: two instances (SHIFT=0 and SHIFT=2) share memories and control,
// results are compared against a plain-arithmetic model of the layer.
module tb_fwd_layer_mac;
  localparam int N_IN = 4, N_OUT = 4, DW = 8;

  logic clk = 1'b0;
  logic rst_i, en_i, pass_i;
  always #5 clk = ~clk;

  logic       rd_a, we_a, done_a, busy_a;
  logic [1:0] xa_a, ya_a;
  logic [3:0] wa_a;
  logic [7:0] yd_a;
  logic [7:0] xd_a = '0, wd_a = '0;
  logic       rd_b, we_b, done_b, busy_b;
  logic [1:0] xa_b, ya_b;
  logic [3:0] wa_b;
  logic [7:0] yd_b;
  logic [7:0] xd_b = '0, wd_b = '0;

  fwd_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACCW(20), .SHIFT(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pass_i(pass_i),
    .rd_en_o(rd_a), .x_addr_o(xa_a), .x_data_i(xd_a), .w_addr_o(wa_a), .w_data_i(wd_a),
    .y_we_o(we_a), .y_addr_o(ya_a), .y_data_o(yd_a), .done_o(done_a), .busy_o(busy_a));

  fwd_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACCW(20), .SHIFT(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pass_i(pass_i),
    .rd_en_o(rd_b), .x_addr_o(xa_b), .x_data_i(xd_b), .w_addr_o(wa_b), .w_data_i(wd_b),
    .y_we_o(we_b), .y_addr_o(ya_b), .y_data_o(yd_b), .done_o(done_b), .busy_o(busy_b));

  logic signed [7:0] x_mem [N_IN];
  logic signed [7:0] w_mem [N_IN*N_OUT];

  // Synchronous-read memories that hold their output while not strobed.
  always @(posedge clk) begin
    if (rd_a) begin
      xd_a <= x_mem[xa_a];
      wd_a <= w_mem[wa_a];
    end
    if (rd_b) begin
      xd_b <= x_mem[xa_b];
      wd_b <= w_mem[wa_b];
    end
  end

  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] qa[$], qb[$];
  int done_cnt_a, done_cyc_a, done_cnt_b, done_cyc_b, reads_a;

  always @(negedge clk) begin
    if (we_a) qa.push_back({ya_a, yd_a});
    if (we_b) qb.push_back({ya_b, yd_b});
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc - t0; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc - t0; end
    if (rd_a) reads_a++;
  end

  int vec = 0, mis = 0;
  int ra[N_OUT], rb[N_OUT];

  function automatic int act(input int s);
    if (s < 0) return 0;
    if (s > 127) return 127;
    return s;
  endfunction

  task automatic compute_ref();
    for (int j = 0; j < N_OUT; j++) begin
      int sum = 0;
      for (int i = 0; i < N_IN; i++) sum += int'(x_mem[i]) * int'(w_mem[j*N_IN+i]);
      ra[j] = act(sum);
      rb[j] = act(sum >>> 2);
    end
  endtask

  task automatic clear_mon();
    qa.delete(); qb.delete();
    done_cnt_a = 0; done_cnt_b = 0; done_cyc_a = -1; done_cyc_b = -1; reads_a = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_IN; i++) x_mem[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 8'($urandom_range(0, 255));
  endtask

  // Drives one pass; en_i is dropped in cycles [s0,s0+n0) and [s1,s1+n1); pass_i held hold extra cycles.
  task automatic run_pass(input int s0, input int n0, input int s1, input int n1, input int hold);
    clear_mon();
    compute_ref();
    @(posedge clk); #1;
    t0 = cyc; pass_i = 1'b1; en_i = 1'b1;
    for (int k = 1; k < 200 && done_cnt_a == 0; k++) begin
      @(posedge clk); #1;
      en_i = !((k >= s0 && k < s0 + n0) || (k >= s1 && k < s1 + n1));
      @(negedge clk); #1;
    end
    en_i = 1'b1;
    vec++;
    if (done_cnt_a == 0) begin
      mis++; $display("FAIL pass_timeout: done_o never seen, required within 200 cycles");
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    pass_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1; pass_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    vec++;
    if ({rd_a, xa_a, wa_a, we_a, ya_a, yd_a, done_a, busy_a} !== 20'd0) begin
      mis++; $display("FAIL reset_outputs_a: got %h required 0", {rd_a, xa_a, wa_a, we_a, ya_a, yd_a, done_a, busy_a});
    end
    vec++;
    if ({rd_b, xa_b, wa_b, we_b, ya_b, yd_b, done_b, busy_b} !== 20'd0) begin
      mis++; $display("FAIL reset_outputs_b: got %h required 0", {rd_b, xa_b, wa_b, we_b, ya_b, yd_b, done_b, busy_b});
    end
    rst_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    vec++;
    if ({busy_a, rd_a, we_a, done_a} !== 4'd0) begin
      mis++; $display("FAIL idle_after_reset: got %b required 0000", {busy_a, rd_a, we_a, done_a});
    end
  endtask

  task automatic test_baseline();
    for (int i = 0; i < N_IN; i++) x_mem[i] = 8'(i + 1);
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 8'sd1;
    run_pass(0, 0, 0, 0, 0);
    vec++; if (done_cyc_a != 25) begin mis++; $display("FAIL base_done_cycle: got %0d required 25", done_cyc_a); end
    vec++; if (done_cnt_a != 1) begin mis++; $display("FAIL base_done_count: got %0d required 1", done_cnt_a); end
    vec++; if (reads_a != 16) begin mis++; $display("FAIL base_reads: got %0d required 16", reads_a); end
    vec++; if (qa.size() != N_OUT) begin mis++; $display("FAIL base_writes: got %0d required %0d", qa.size(), N_OUT); end
    for (int j = 0; j < N_OUT && j < qa.size(); j++) begin
      vec++; if (qa[j] !== {2'(j), 8'd10}) begin mis++; $display("FAIL base_y%0d: got %h required %h", j, qa[j], {2'(j), 8'd10}); end
    end
    for (int j = 0; j < N_OUT && j < qb.size(); j++) begin
      vec++; if (qb[j] !== {2'(j), 8'd2}) begin mis++; $display("FAIL shift_y%0d: got %h required %h", j, qb[j], {2'(j), 8'd2}); end
    end
    vec++; if (busy_a !== 1'b0) begin mis++; $display("FAIL base_busy_after: got %b required 0", busy_a); end
  endtask

  task automatic test_relu_sat();
    fill_random();
    for (int i = 0; i < N_IN; i++) begin
      x_mem[i] = 8'sd127; w_mem[i] = -8'sd1; w_mem[N_IN+i] = 8'sd127;
    end
    run_pass(0, 0, 0, 0, 0);
    vec++; if (qa.size() != N_OUT || qb.size() != N_OUT) begin mis++; $display("FAIL relu_writes: got %0d/%0d required %0d", qa.size(), qb.size(), N_OUT); end
    vec++; if (qa.size() > 1 && qa[0][7:0] !== 8'd0) begin mis++; $display("FAIL relu_y0: got %0d required 0", qa[0][7:0]); end
    vec++; if (qa.size() > 1 && qa[1][7:0] !== 8'd127) begin mis++; $display("FAIL sat_y1: got %0d required 127", qa[1][7:0]); end
    for (int j = 0; j < N_OUT && j < qa.size() && j < qb.size(); j++) begin
      vec++; if (qa[j] !== {2'(j), 8'(ra[j])}) begin mis++; $display("FAIL relu_a_y%0d: got %h required %h", j, qa[j], {2'(j), 8'(ra[j])}); end
      vec++; if (qb[j] !== {2'(j), 8'(rb[j])}) begin mis++; $display("FAIL relu_b_y%0d: got %h required %h", j, qb[j], {2'(j), 8'(rb[j])}); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < N_IN; i++) x_mem[i] = 8'(i + 1);
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 8'sd1;
    run_pass(8, 3, 14, 1, 0);
    vec++; if (done_cyc_a != 29) begin mis++; $display("FAIL stall_done_cycle: got %0d required 29", done_cyc_a); end
    vec++; if (done_cyc_b != 29) begin mis++; $display("FAIL stall_done_cycle_b: got %0d required 29", done_cyc_b); end
    vec++; if (reads_a != 16) begin mis++; $display("FAIL stall_reads: got %0d required 16", reads_a); end
    vec++; if (qa.size() != N_OUT) begin mis++; $display("FAIL stall_writes: got %0d required %0d", qa.size(), N_OUT); end
    for (int j = 0; j < N_OUT && j < qa.size(); j++) begin
      vec++; if (qa[j] !== {2'(j), 8'd10}) begin mis++; $display("FAIL stall_y%0d: got %h required %h", j, qa[j], {2'(j), 8'd10}); end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int s0, n0;
      fill_random();
      s0 = int'($urandom_range(1, 20));
      n0 = int'($urandom_range(0, 3));
      run_pass(s0, n0, 0, 0, 0);
      vec++; if (done_cyc_a != 25 + n0) begin mis++; $display("FAIL rand%0d_done: got %0d required %0d", p, done_cyc_a, 25 + n0); end
      vec++; if (qa.size() != N_OUT || qb.size() != N_OUT) begin mis++; $display("FAIL rand%0d_writes: got %0d/%0d required %0d", p, qa.size(), qb.size(), N_OUT); end
      for (int j = 0; j < N_OUT && j < qa.size() && j < qb.size(); j++) begin
        vec++; if (qa[j] !== {2'(j), 8'(ra[j])}) begin mis++; $display("FAIL rand%0d_a_y%0d: got %h required %h", p, j, qa[j], {2'(j), 8'(ra[j])}); end
        vec++; if (qb[j] !== {2'(j), 8'(rb[j])}) begin mis++; $display("FAIL rand%0d_b_y%0d: got %h required %h", p, j, qb[j], {2'(j), 8'(rb[j])}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; pass_i = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    vec++; if ({we_a, ya_a} !== 3'b110) begin mis++; $display("FAIL rstmid_in_write: got %b required 110", {we_a, ya_a}); end
    rst_i = 1'b1;
    #1;
    vec++;
    if ({rd_a, xa_a, wa_a, we_a, ya_a, yd_a, done_a, busy_a} !== 20'd0) begin
      mis++; $display("FAIL rstmid_outputs: got %h required 0", {rd_a, xa_a, wa_a, we_a, ya_a, yd_a, done_a, busy_a});
    end
    pass_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    fill_random();
    run_pass(0, 0, 0, 0, 0);
    vec++; if (done_cyc_a != 25) begin mis++; $display("FAIL rstmid_done_cycle: got %0d required 25", done_cyc_a); end
    vec++; if (qa.size() != N_OUT) begin mis++; $display("FAIL rstmid_writes: got %0d required %0d", qa.size(), N_OUT); end
    for (int j = 0; j < N_OUT && j < qa.size(); j++) begin
      vec++; if (qa[j] !== {2'(j), 8'(ra[j])}) begin mis++; $display("FAIL rstmid_y%0d: got %h required %h", j, qa[j], {2'(j), 8'(ra[j])}); end
    end
  endtask

  task automatic test_hold();
    fill_random();
    run_pass(0, 0, 0, 0, 10);
    vec++; if (done_cnt_a != 1) begin mis++; $display("FAIL hold_done_count: got %0d required 1", done_cnt_a); end
    vec++; if (reads_a != 16) begin mis++; $display("FAIL hold_reads: got %0d required 16", reads_a); end
    vec++; if (qa.size() != N_OUT) begin mis++; $display("FAIL hold_writes: got %0d required %0d", qa.size(), N_OUT); end
  endtask

  task automatic test_abort();
    fill_random();
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; pass_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pass_i = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    vec++; if (qa.size() != 0) begin mis++; $display("FAIL abort_writes: got %0d required 0", qa.size()); end
    vec++; if (done_cnt_a != 0) begin mis++; $display("FAIL abort_done: got %0d required 0", done_cnt_a); end
    vec++; if (busy_a !== 1'b0) begin mis++; $display("FAIL abort_busy: got %b required 0", busy_a); end
    run_pass(0, 0, 0, 0, 0);
    vec++; if (done_cyc_a != 25) begin mis++; $display("FAIL after_abort_done: got %0d required 25", done_cyc_a); end
    for (int j = 0; j < N_OUT && j < qa.size(); j++) begin
      vec++; if (qa[j] !== {2'(j), 8'(ra[j])}) begin mis++; $display("FAIL after_abort_y%0d: got %h required %h", j, qa[j], {2'(j), 8'(ra[j])}); end
    end
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) x_mem[i] = '0;
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = '0;
    test_reset();
    test_baseline();
    test_relu_sat();
    test_stall();
    test_random();
    test_reset_mid();
    test_hold();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
